// File: rtl/target_power_sequencer_pkg.sv
// Shared register map and state encoding for the target power sequencer.
package target_power_sequencer_pkg;

    localparam logic [7:0] SEQCTRL_ADDR = 8'h60;
    localparam logic [7:0] SEQTIME_ADDR = 8'h61;
    localparam logic [7:0] SEQSTAT_ADDR = 8'h62;

    localparam int unsigned CtrlStartBit = 0;
    localparam int unsigned CtrlAbortBit = 1;
    localparam int unsigned CtrlSkipBit  = 2;

    localparam int unsigned SeqTimeBytes = 6;

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StPwrOff    = 3'd1,
        StPwrSettle = 3'd2,
        StRstHold   = 3'd3,
        StDone      = 3'd4
    } seq_state_e;

endpackage

// File: rtl/target_power_sequencer_seq_timer.sv
// Prescaled 16-bit down-counter: reloads on load_i, ticks once every Prescale cycles until zero.
module target_power_sequencer_seq_timer #(
    parameter int unsigned Prescale = 96
) (
    input  logic        clk_usb,
    input  logic        reset,
    input  logic        load_i,
    input  logic [15:0] load_val_i,
    output logic        zero_o
);

    localparam int unsigned PsW = (Prescale > 1) ? $clog2(Prescale) : 1;
    localparam logic [PsW-1:0] PsLast = PsW'(Prescale - 1);

    logic [PsW-1:0] ps_q, ps_d;
    logic [15:0]    cnt_q, cnt_d;

    always_comb begin
        ps_d  = ps_q;
        cnt_d = cnt_q;
        if (load_i) begin
            ps_d  = '0;
            cnt_d = load_val_i;
        end else if (cnt_q != 16'd0) begin
            // Saturates at zero: the prescaler stops once the count is exhausted.
            if (ps_q == PsLast) begin
                ps_d  = '0;
                cnt_d = cnt_q - 16'd1;
            end else begin
                ps_d = ps_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_usb) begin
        if (reset) begin
            ps_q  <= '0;
            cnt_q <= 16'd0;
        end else begin
            ps_q  <= ps_d;
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == 16'd0);

endmodule

// File: rtl/target_power_sequencer.sv
// Target power-cycle / nRST sequencer with a small byte-wide register interface.
module target_power_sequencer
    import target_power_sequencer_pkg::*;
#(
    parameter int unsigned pBYTECNT_SIZE = 7,
    parameter int unsigned pPRESCALE     = 96
) (
    input  logic                     clk_usb,
    input  logic                     reset,
    input  logic [7:0]               reg_address,
    input  logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
    input  logic [7:0]               reg_datai,
    output logic [7:0]               reg_datao,
    input  logic                     reg_read,
    input  logic                     reg_write,
    input  logic                     req_targetpower_off,
    output logic                     targetpower_off,
    output logic                     nrst_oe,
    output logic                     nrst_o,
    output logic                     busy,
    output logic                     done_o
);

    seq_state_e       state_q, state_d;
    logic [5:0][7:0]  seqtime_q;
    logic             skip_q;
    logic [7:0]       datao_q, datao_d;
    logic             pwr_off_q, pwr_off_d, oe_q, oe_d, rst_lvl_q, rst_lvl_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic             ctrl_wr, time_wr, byte_ok, start, abort;
    logic             tmr_load, tmr_zero;
    logic [15:0]      tmr_val;

    assign ctrl_wr = reg_write && (reg_address == SEQCTRL_ADDR);
    assign time_wr = reg_write && (reg_address == SEQTIME_ADDR);
    assign byte_ok = reg_bytecnt < pBYTECNT_SIZE'(SeqTimeBytes);
    assign abort   = ctrl_wr && reg_datai[CtrlAbortBit];
    assign start   = ctrl_wr && reg_datai[CtrlStartBit] && !reg_datai[CtrlAbortBit];

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:      if (start) state_d = reg_datai[CtrlSkipBit] ? StRstHold : StPwrOff;
            StPwrOff:    if (tmr_zero) state_d = StPwrSettle;
            StPwrSettle: if (tmr_zero) state_d = StRstHold;
            StRstHold:   if (tmr_zero) state_d = StDone;
            StDone:      state_d = StIdle;
            default:     state_d = StIdle;
        endcase
        if (abort) state_d = StIdle;
    end

    // Duration is captured on entry, so SEQTIME edits only affect states not yet entered.
    assign tmr_load = (state_d != state_q);
    always_comb begin
        tmr_val = 16'd0;
        case (state_d)
            StPwrOff:    tmr_val = {seqtime_q[1], seqtime_q[0]};
            StPwrSettle: tmr_val = {seqtime_q[3], seqtime_q[2]};
            StRstHold:   tmr_val = {seqtime_q[5], seqtime_q[4]};
            default:     tmr_val = 16'd0;
        endcase
    end

    target_power_sequencer_seq_timer #(
        .Prescale (pPRESCALE)
    ) u_seq_timer (
        .clk_usb    (clk_usb),
        .reset      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        pwr_off_d = 1'b0;
        oe_d      = 1'b1;
        rst_lvl_d = 1'b0;
        busy_d    = 1'b1;
        done_d    = 1'b0;
        case (state_d)
            StIdle: begin
                oe_d      = 1'b0;
                rst_lvl_d = 1'b1;
                busy_d    = 1'b0;
            end
            StPwrOff: pwr_off_d = 1'b1;
            StDone: begin
                rst_lvl_d = 1'b1;
                done_d    = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        datao_d = 8'h00;
        if (reg_read) begin
            case (reg_address)
                SEQCTRL_ADDR: datao_d = {5'b00000, skip_q, 2'b00};
                SEQTIME_ADDR: if (byte_ok) datao_d = seqtime_q[reg_bytecnt[2:0]];
                SEQSTAT_ADDR: datao_d = {4'b0000, busy_q, state_q};
                default:      datao_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk_usb) begin
        if (reset) begin
            state_q   <= StIdle;
            seqtime_q <= '0;
            skip_q    <= 1'b0;
            datao_q   <= 8'h00;
            pwr_off_q <= 1'b0;
            oe_q      <= 1'b0;
            rst_lvl_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            datao_q   <= datao_d;
            pwr_off_q <= pwr_off_d;
            oe_q      <= oe_d;
            rst_lvl_q <= rst_lvl_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            if (ctrl_wr) skip_q <= reg_datai[CtrlSkipBit];
            if (time_wr && byte_ok) seqtime_q[reg_bytecnt[2:0]] <= reg_datai;
        end
    end

    // Only the idle passthrough of the power request is combinational.
    assign targetpower_off = (state_q == StIdle) ? req_targetpower_off : pwr_off_q;
    assign nrst_oe         = oe_q;
    assign nrst_o          = rst_lvl_q;
    assign busy            = busy_q;
    assign done_o          = done_q;
    assign reg_datao       = datao_q;

endmodule

// File: tb/tb_target_power_sequencer.sv
// Scoreboard bench: output-segment and read-data expectations queued by the driver, checked by a monitor.
module tb_target_power_sequencer;
    import target_power_sequencer_pkg::*;

    localparam int P = 4;

    logic       clk_usb = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] reg_address = 8'h00;
    logic [6:0] reg_bytecnt = 7'd0;
    logic [7:0] reg_datai = 8'h00;
    logic [7:0] reg_datao;
    logic       reg_read = 1'b0, reg_write = 1'b0, req = 1'b0;
    logic       tpo, nrst_oe, nrst_o, busy, done_o;

    always #5 clk_usb = ~clk_usb;

    target_power_sequencer #(
        .pBYTECNT_SIZE (7),
        .pPRESCALE     (P)
    ) dut (
        .clk_usb             (clk_usb),
        .reset               (reset),
        .reg_address         (reg_address),
        .reg_bytecnt         (reg_bytecnt),
        .reg_datai           (reg_datai),
        .reg_datao           (reg_datao),
        .reg_read            (reg_read),
        .reg_write           (reg_write),
        .req_targetpower_off (req),
        .targetpower_off     (tpo),
        .nrst_oe             (nrst_oe),
        .nrst_o              (nrst_o),
        .busy                (busy),
        .done_o              (done_o)
    );

    typedef struct {
        logic tpo;
        logic oe;
        logic o;
        logic done;
        int   len;
    } seg_t;

    seg_t       exp_q[$];
    logic [7:0] rd_q[$];
    int         n_checks = 0, n_fail = 0;
    int         t_off = 0, t_set = 0, t_rst = 0;
    logic       mon_en = 1'b0, rd_seen = 1'b0, in_seg = 1'b0;
    seg_t       cur;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    task automatic close_seg();
        seg_t e;
        if (exp_q.size() == 0) begin
            fail_now("unexpected busy segment");
        end else begin
            e = exp_q.pop_front();
            check("seg targetpower_off", 32'(cur.tpo), 32'(e.tpo));
            check("seg nrst_oe", 32'(cur.oe), 32'(e.oe));
            check("seg nrst_o", 32'(cur.o), 32'(e.o));
            check("seg done_o", 32'(cur.done), 32'(e.done));
            check("seg length", 32'(cur.len), 32'(e.len));
        end
    endtask

    always @(posedge clk_usb) rd_seen <= reg_read;

    // Monitor: run-length encodes the busy output tuple and compares each closed run.
    always @(negedge clk_usb) begin
        if (mon_en) begin
            if (rd_seen) begin
                if (rd_q.size() == 0) fail_now("unexpected read data");
                else check("read data", 32'(reg_datao), 32'(rd_q.pop_front()));
            end else begin
                check("datao zero without read", 32'(reg_datao), 32'd0);
            end
            if (busy === 1'b1) begin
                if (in_seg && cur.tpo === tpo && cur.oe === nrst_oe && cur.o === nrst_o
                    && cur.done === done_o) begin
                    cur.len++;
                end else begin
                    if (in_seg) close_seg();
                    cur.tpo  = tpo;
                    cur.oe   = nrst_oe;
                    cur.o    = nrst_o;
                    cur.done = done_o;
                    cur.len  = 1;
                    in_seg   = 1'b1;
                end
            end else if (in_seg) begin
                close_seg();
                in_seg = 1'b0;
                check("idle nrst_oe", 32'(nrst_oe), 32'd0);
                check("idle nrst_o", 32'(nrst_o), 32'd1);
                check("idle done_o", 32'(done_o), 32'd0);
                check("idle targetpower_off passthrough", 32'(tpo), 32'(req));
            end
        end
    end

    task automatic cyc_idle();
        @(posedge clk_usb);
        #1;
    endtask

    task automatic do_write(input logic [7:0] a, input int bc, input logic [7:0] d);
        reg_address = a;
        reg_bytecnt = 7'(bc);
        reg_datai   = d;
        reg_write   = 1'b1;
        @(posedge clk_usb);
        #1;
        reg_write = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] a, input int bc, input logic [7:0] exp);
        rd_q.push_back(exp);
        reg_address = a;
        reg_bytecnt = 7'(bc);
        reg_read    = 1'b1;
        @(posedge clk_usb);
        #1;
        reg_read = 1'b0;
    endtask

    task automatic set_times(input int off, input int st, input int rst);
        do_write(SEQTIME_ADDR, 0, 8'(off));
        do_write(SEQTIME_ADDR, 1, 8'(off >> 8));
        do_write(SEQTIME_ADDR, 2, 8'(st));
        do_write(SEQTIME_ADDR, 3, 8'(st >> 8));
        do_write(SEQTIME_ADDR, 4, 8'(rst));
        do_write(SEQTIME_ADDR, 5, 8'(rst >> 8));
        t_off = off;
        t_set = st;
        t_rst = rst;
    endtask

    function automatic int seq_len(input int skip, input int trst);
        int n;
        n = trst * P + 1 + 1;
        if (skip == 0) n += (t_off * P + 1) + (t_set * P + 1);
        return n;
    endfunction

    // Reference: ordered phase list with durations, merged where outputs match, cut at limit.
    task automatic push_expected(input int skip, input int trst, input int limit);
        seg_t raw[4];
        seg_t pend;
        int   n = 0, remaining, l;
        bit   have = 0;
        if (skip == 0) begin
            raw[n] = '{1'b1, 1'b1, 1'b0, 1'b0, t_off * P + 1}; n++;
            raw[n] = '{1'b0, 1'b1, 1'b0, 1'b0, t_set * P + 1}; n++;
        end
        raw[n] = '{1'b0, 1'b1, 1'b0, 1'b0, trst * P + 1}; n++;
        raw[n] = '{1'b0, 1'b1, 1'b1, 1'b1, 1}; n++;
        remaining = (limit < 0) ? 1 << 30 : limit;
        for (int i = 0; i < n; i++) begin
            if (remaining == 0) break;
            l = (raw[i].len < remaining) ? raw[i].len : remaining;
            remaining -= l;
            if (have && pend.tpo == raw[i].tpo && pend.oe == raw[i].oe && pend.o == raw[i].o
                && pend.done == raw[i].done) begin
                pend.len += l;
            end else begin
                if (have) exp_q.push_back(pend);
                pend     = raw[i];
                pend.len = l;
                have     = 1;
            end
        end
        if (have) exp_q.push_back(pend);
    endtask

    // s: busy cycle of a redundant START; a: busy cycle of ABORT/reset (-1 = none).
    task automatic run_seq(input int skip, input int chg, input int new_rst, input int s,
                           input int a, input int use_rst);
        int   trst, total, k;
        logic [7:0] ctl;
        trst  = (chg != 0 && skip == 0) ? new_rst : t_rst;
        total = seq_len(skip, trst);
        ctl   = (skip != 0) ? 8'h04 : 8'h00;
        push_expected(skip, trst, (a >= 0) ? a + 1 : -1);
        do_write(SEQCTRL_ADDR, 0, ctl | 8'h01);
        for (int c = 0; c <= total + 1; c++) begin
            if (c == 0 && chg != 0 && skip == 0) begin
                do_write(SEQTIME_ADDR, 4, 8'(new_rst));
            end else if (c == s) begin
                do_write(SEQCTRL_ADDR, 0, ctl | 8'h01);
            end else if (c == a) begin
                if (use_rst != 0) begin
                    reset = 1'b1;
                    cyc_idle();
                    reset = 1'b0;
                end else begin
                    do_write(SEQCTRL_ADDR, 0, ctl | 8'h02);
                end
            end else begin
                cyc_idle();
            end
        end
        if (use_rst != 0) begin
            t_off = 0;
            t_set = 0;
            t_rst = 0;
        end else begin
            t_rst = trst;
        end
        k = 0;
        while (busy !== 1'b0 && k < 100) begin
            cyc_idle();
            k++;
        end
        if (k == 100) fail_now("timeout waiting for idle");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int off, st, rs, skip, chg, nr, trst, total, s, a;
        repeat (2) @(posedge clk_usb);
        #1;
        reset = 1'b0;
        check("reset busy", 32'(busy), 32'd0);
        check("reset nrst_oe", 32'(nrst_oe), 32'd0);
        check("reset nrst_o", 32'(nrst_o), 32'd1);
        check("reset done_o", 32'(done_o), 32'd0);
        check("reset reg_datao", 32'(reg_datao), 32'd0);
        check("reset tpo passthrough low", 32'(tpo), 32'd0);
        req = 1'b1;
        #1;
        check("reset tpo passthrough high", 32'(tpo), 32'd1);
        req = 1'b0;
        mon_en = 1'b1;
        cyc_idle();

        do_read(SEQTIME_ADDR, 0, 8'h00);
        do_read(SEQTIME_ADDR, 5, 8'h00);
        do_read(SEQSTAT_ADDR, 0, 8'h00);

        for (int i = 0; i < 6; i++) do_write(SEQTIME_ADDR, i, 8'(8'h11 * (i + 1)));
        for (int i = 0; i < 6; i++) do_read(SEQTIME_ADDR, i, 8'(8'h11 * (i + 1)));
        do_read(SEQTIME_ADDR, 6, 8'h00);
        do_read(8'h00, 0, 8'h00);

        set_times(2, 1, 3);
        req = 1'b1;
        run_seq(0, 0, 0, 20, -1, 0);
        do_read(SEQSTAT_ADDR, 0, 8'h00);
        do_read(SEQCTRL_ADDR, 0, 8'h00);

        set_times(2, 1, 0);
        run_seq(1, 0, 0, 1, -1, 0);
        do_read(SEQCTRL_ADDR, 0, 8'h04);

        set_times(2, 1, 3);
        req = 1'b1;
        run_seq(0, 0, 0, 1, 11, 0);

        do_write(SEQCTRL_ADDR, 0, 8'h03);
        repeat (4) cyc_idle();
        do_read(SEQSTAT_ADDR, 0, 8'h00);

        req = 1'b0;
        run_seq(0, 0, 0, 1, 3, 1);
        for (int i = 0; i < 6; i++) do_read(SEQTIME_ADDR, i, 8'h00);
        do_read(SEQSTAT_ADDR, 0, 8'h00);
        do_read(SEQCTRL_ADDR, 0, 8'h00);

        for (int it = 0; it < 20; it++) begin
            off = int'($urandom_range(0, 3));
            st  = int'($urandom_range(0, 3));
            rs  = int'($urandom_range(0, 3));
            set_times(off, st, rs);
            req   = 1'($urandom_range(0, 1));
            skip  = int'($urandom_range(0, 1));
            chg   = (skip != 0) ? 0 : int'($urandom_range(0, 1));
            nr    = int'($urandom_range(0, 3));
            trst  = (chg != 0) ? nr : rs;
            total = seq_len(skip, trst);
            s     = int'($urandom_range(1, total - 1));
            a     = ($urandom_range(0, 2) == 0) ? int'($urandom_range(s + 1, total + 1)) : -1;
            run_seq(skip, chg, nr, s, a, 0);
            do_read(SEQSTAT_ADDR, 0, 8'h00);
        end

        repeat (4) cyc_idle();
        check("segment scoreboard drained", 32'(exp_q.size()), 32'd0);
        check("read scoreboard drained", 32'(rd_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
